delay_tap_reader: RTL and testbench

- Read-side companion to the circular-buffer delay writer in the audio delay path.
- Tracks the writer's strobe and address, and issues one RAM read per written sample at address (wr_addr − delay) mod DEPTH.
- Absorbs the 1-cycle RAM read latency and presents delayed samples on a valid/ready stream towards the mixer.
- Outputs zeros until the buffer holds at least `delay` samples, so the output stays 1:1 aligned with writer strobes.

---
 rtl/delay_tap_reader.sv | 215 +++++++++++++++++++++
 tb/tb_delay_tap_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_tap_reader.sv
// ---------------------------------------------------------------------------
// delay_tap_reader
//
// Read-side companion to the circular-buffer delay writer. For every sample
// the writer stores, this block issues one RAM read at (wr_addr - delay)
// modulo DEPTH. It absorbs the single-cycle RAM read latency and hands the
// delayed samples to the mixer over a valid/ready stream. Until the ring
// holds at least `delay` samples it emits zeros instead, so the output stays
// one-for-one with writer strobes.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_strobe       writer stored a sample this cycle
//   wr_addr         address written this cycle (valid with wr_strobe)
//   delay_in        requested delay in samples
//   delay_load      latch delay_in (clamped to 1..DEPTH-1) as the target
//   ram_rd_en       RAM read enable (registered)
//   ram_rd_addr     RAM read address (registered)
//   ram_rd_data     RAM data, valid while the registered request is presented
//   tap_out         delayed sample (head of the output FIFO)
//   tap_valid       tap_out valid
//   tap_ready       consumer accepts tap_out
//   overrun         sticky flag: a sample was dropped on a full FIFO
//   delay_cur       delay currently applied
//
// Build option:
//   DELAY_SLEW_EN   when defined, delay_cur walks one step per strobe toward
//                   the target instead of jumping, and a running stream never
//                   falls back to emitting zeros.
// ---------------------------------------------------------------------------
module delay_tap_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 384000,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_strobe,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] delay_in,
    input  logic                  delay_load,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] tap_out,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] delay_cur
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_DELAY = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
    localparam int                    FIFO_DEPTH = 4;
    localparam logic [2:0]            FIFO_FULL  = 3'(FIFO_DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   delay_target;
    logic [ADDR_WIDTH-1:0]   delay_clamped;
    logic [ADDR_WIDTH-1:0]   delay_next;
    logic [ADDR_WIDTH-1:0]   fill_count;
    logic [ADDR_WIDTH:0]     rd_diff;
    logic [ADDR_WIDTH-1:0]   rd_addr_next;
    logic                    read_now;
    logic                    req_valid;

    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [1:0]              fifo_wr_ptr;
    logic [1:0]              fifo_rd_ptr;
    logic [2:0]              fifo_count;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    push_accept;
    logic [DATA_WIDTH-1:0]   push_data;

    // A zero delay would read the word being written in the same cycle, and
    // anything at or beyond DEPTH would alias onto a shorter delay.
    always_comb begin
        delay_clamped = delay_in;
        if (delay_in == '0) begin
            delay_clamped = ONE_ADDR;
        end else if ({1'b0, delay_in} >= DEPTH_EXT) begin
            delay_clamped = MAX_DELAY;
        end
    end

    // The target is only a holding register; it reaches delay_cur on the
    // next strobe so a sample is never read with a half-changed delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_target <= ONE_ADDR;
        end else if (delay_load) begin
            delay_target <= delay_clamped;
        end
    end

`ifdef DELAY_SLEW_EN
    // One step per strobe keeps the read pointer moving smoothly. Stepping up
    // re-reads the previous address, which is always a written sample.
    always_comb begin
        delay_next = delay_cur;
        if (delay_cur < delay_target) begin
            delay_next = delay_cur + ONE_ADDR;
        end else if (delay_cur > delay_target) begin
            delay_next = delay_cur - ONE_ADDR;
        end
    end

    always_comb begin
        state_next = state;
        if (state == FILL && fill_count >= delay_next) begin
            state_next = RUN;
        end
    end
`else
    logic delay_changed;

    assign delay_next    = delay_target;
    assign delay_changed = (delay_next != delay_cur);

    // While running with an unchanged delay the fill count can only grow, so
    // the only way back to FILL is a freshly applied, longer delay.
    always_comb begin
        state_next = state;
        case (state)
            FILL: if (fill_count >= delay_next) state_next = RUN;
            RUN:  if (delay_changed && delay_next > fill_count) state_next = FILL;
            default: state_next = FILL;
        endcase
    end
`endif

    assign read_now = (state_next == RUN);

    // One extra bit catches the borrow; DEPTH need not be a power of two, so
    // a negative difference is folded back by adding DEPTH explicitly.
    assign rd_diff      = {1'b0, wr_addr} - {1'b0, delay_next};
    assign rd_addr_next = rd_diff[ADDR_WIDTH] ? ADDR_WIDTH'(rd_diff + DEPTH_EXT)
                                              : rd_diff[ADDR_WIDTH-1:0];

    // Request stage. Each strobe registers either a RAM read or a zero
    // sample; both flow through the same stage so ordering holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            delay_cur   <= ONE_ADDR;
            fill_count  <= '0;
            req_valid   <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
        end else if (wr_strobe) begin
            state     <= state_next;
            delay_cur <= delay_next;
            req_valid <= 1'b1;
            ram_rd_en <= read_now;
            if (read_now) begin
                ram_rd_addr <= rd_addr_next;
            end
            if (fill_count != MAX_DELAY) begin
                fill_count <= fill_count + ONE_ADDR;
            end
        end else begin
            req_valid <= 1'b0;
            ram_rd_en <= 1'b0;
        end
    end

    assign push        = req_valid;
    assign push_data   = ram_rd_en ? ram_rd_data : '0;
    assign pop         = tap_valid && tap_ready;
    assign fifo_full   = (fifo_count == FIFO_FULL);
    assign push_accept = push && (!fifo_full || pop);

    // First-word-fall-through output FIFO. At full, a simultaneous pop frees
    // the head slot, which is exactly the slot the write pointer targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            overrun     <= 1'b0;
        end else begin
            if (push_accept) begin
                fifo_mem[fifo_wr_ptr] <= push_data;
                fifo_wr_ptr           <= fifo_wr_ptr + 2'd1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            end
            if (push_accept && !pop) begin
                fifo_count <= fifo_count + 3'd1;
            end else if (!push_accept && pop) begin
                fifo_count <= fifo_count - 3'd1;
            end
            if (push && fifo_full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign tap_out   = fifo_mem[fifo_rd_ptr];
    assign tap_valid = (fifo_count != 3'd0);

endmodule

// File: tb/tb_delay_tap_reader.sv
// ---------------------------------------------------------------------------
// tb_delay_tap_reader
//
// Drives delay_tap_reader (DEPTH=16, ADDR_WIDTH=5 so out-of-range delays can
// be requested) together with a small writer/RAM model. Expected samples come
// from a history of everything written: a strobe yields the sample written
// `delay` strobes earlier once at least `delay` strobes have been seen since
// reset, and zero otherwise.
// ---------------------------------------------------------------------------
module tb_delay_tap_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] delay_in;
    logic          delay_load;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] tap_out;
    logic          tap_valid;
    logic          tap_ready;
    logic          overrun;
    logic [AW-1:0] delay_cur;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] ram_mem [32];

    int            n_checks = 0;
    int            n_fail   = 0;

    int            strobe_cnt;
    int            target_model;
    int            applied_model;
    int            waddr_model;
    logic [DW-1:0] hist [$];
    logic [DW-1:0] bp_expected [5];
    logic [DW-1:0] sample_e;

    delay_tap_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .delay_in    (delay_in),
        .delay_load  (delay_load),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .tap_out     (tap_out),
        .tap_valid   (tap_valid),
        .tap_ready   (tap_ready),
        .overrun     (overrun),
        .delay_cur   (delay_cur)
    );

    always #5 clk = ~clk;

    // Writer side of the ring plus a RAM whose read port answers the
    // registered request during the cycle it is presented.
    always @(posedge clk) begin
        if (wr_strobe) ram_mem[wr_addr] <= wr_data;
    end

    assign ram_rd_data = ram_rd_en ? ram_mem[ram_rd_addr] : 32'hDEAD_BEEF;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int clampDelay(input int d);
        if (d == 0) return 1;
        if (d >= DEPTH) return DEPTH - 1;
        return d;
    endfunction

    task automatic modelReset;
        strobe_cnt    = 0;
        target_model  = 1;
        applied_model = 1;
    endtask

    task automatic loadDelay(input int d);
        delay_in   = AW'(d);
        delay_load = 1'b1;
        tick;
        delay_load = 1'b0;
        target_model = clampDelay(d);
        checkOutput("delay_hold", delay_cur, applied_model);
    endtask

    // One writer strobe; returns the sample the reader should emit for it.
    task automatic applyStimulus(input logic [DW-1:0] data, output logic [DW-1:0] exp_sample);
        int applied;
        int exp_addr;
        bit reads;
        applied    = target_model;
        reads      = (strobe_cnt >= applied);
        exp_sample = reads ? hist[hist.size() - applied] : '0;
        exp_addr   = (waddr_model - applied + DEPTH) % DEPTH;
        wr_addr    = AW'(waddr_model);
        wr_data    = data;
        wr_strobe  = 1'b1;
        tick;
        wr_strobe  = 1'b0;
        hist.push_back(data);
        waddr_model   = (waddr_model + 1) % DEPTH;
        applied_model = applied;
        if (strobe_cnt < DEPTH - 1) strobe_cnt++;
        checkOutput("rd_en", ram_rd_en, reads);
        if (reads) checkOutput("rd_addr", ram_rd_addr, exp_addr);
        checkOutput("delay_cur", delay_cur, applied);
    endtask

    // Isolated strobe with tap_ready high: valid exactly two clocks later,
    // for one cycle only.
    task automatic strobeAndCheck(input logic [DW-1:0] data);
        logic [DW-1:0] e;
        applyStimulus(data, e);
        checkOutput("valid_early", tap_valid, 0);
        tick;
        checkOutput("tap_valid", tap_valid, 1);
        checkOutput("tap_out", tap_out, e);
        tick;
        checkOutput("tap_pop", tap_valid, 0);
        tick;
    endtask

    initial begin
        rst        = 1'b1;
        wr_strobe  = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        delay_in   = '0;
        delay_load = 1'b0;
        tap_ready  = 1'b1;
        waddr_model = 0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rd_en", ram_rd_en, 0);
        checkOutput("rst_rd_addr", ram_rd_addr, 0);
        checkOutput("rst_tap_out", tap_out, 0);
        checkOutput("rst_tap_valid", tap_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_delay_cur", delay_cur, 1);
        rst = 1'b0;
        tick;

        $display("[TB] fill and read-back, delay 3");
        loadDelay(3);
        for (int i = 1; i <= 8; i++) strobeAndCheck(DW'(i));

        $display("[TB] address wrap, delay 5");
        loadDelay(5);
        for (int i = 0; i < 12; i++) strobeAndCheck($urandom);

        $display("[TB] delay clamp");
        loadDelay(0);
        strobeAndCheck($urandom);
        loadDelay(20);
        strobeAndCheck($urandom);

        $display("[TB] backpressure and overrun");
        loadDelay(4);
        strobeAndCheck($urandom);
        checkOutput("overrun_pre", overrun, 0);
        tap_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus($urandom, bp_expected[i]);
        repeat (2) tick;
        checkOutput("overrun_set", overrun, 1);
        tap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", tap_valid, 1);
            checkOutput("drain_data", tap_out, bp_expected[i]);
            tick;
        end
        checkOutput("drain_empty", tap_valid, 0);
        checkOutput("overrun_sticky", overrun, 1);

        $display("[TB] async reset mid-stream");
        tap_ready = 1'b0;
        applyStimulus($urandom, sample_e);
        tick;
        checkOutput("pre_rst_valid", tap_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", tap_valid, 0);
        checkOutput("arst_overrun", overrun, 0);
        checkOutput("arst_delay", delay_cur, 1);
        #2;
        rst = 1'b0;
        tick;
        modelReset();
        tap_ready = 1'b1;
        strobeAndCheck($urandom);

        $display("[TB] delay increase forces refill");
        loadDelay(8);
        while (strobe_cnt < 10) strobeAndCheck($urandom);
        loadDelay(12);
        for (int i = 0; i < 4; i++) strobeAndCheck($urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
